cam_axi_wr_ctrl: RTL

CAM_AXI_WR_CTRL -- requirements
Module: cam_axi_wr_ctrl

---
 rtl/cam_axi_wr_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cam_axi_wr_ctrl.sv
// Camera pixel stream to AXI3 write master. Each frame buffer is written as a
// sequence of 16-beat x 8-byte bursts, one burst outstanding at a time, and the
// buffers are used in turn as a ring of NUM_FRAMES buffers.
module cam_axi_wr_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] FRAME_BYTES = 32'h0002_5800,
  parameter int unsigned NUM_FRAMES  = 3
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [63:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [7:0]  awid,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [2:0]  awprot,
  output logic [3:0]  awcache,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic [7:0]  wid,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic [7:0]  bid,
  input  logic        bvalid,
  output logic        bready,
  output logic [7:0]  frame_num,
  output logic        frame_done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  buf_idx;
  logic [31:0] offset;
  logic [3:0]  beat;
  logic        frame_end;
  logic        bid_unused;

  // Only ID 0 is ever issued, so the response ID carries no information.
  assign bid_unused = ^bid;

  assign awlen   = 4'hF;
  assign awsize  = 3'b011;
  assign awburst = 2'b01;
  assign awid    = '0;
  assign wid     = '0;
  assign awlock  = '0;
  assign awprot  = '0;
  assign awcache = 4'b0011;
  assign wstrb   = '1;
  assign wdata   = pix_data;

  // Registers only move outside ADDR, so the address is stable while awvalid is high.
  assign awaddr    = BASE_ADDR + 32'(buf_idx) * FRAME_BYTES + offset;
  assign frame_end = (offset == FRAME_BYTES);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state decode and channel handshake outputs.
  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    pix_ready = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    unique case (state)
      IDLE: if (enable) state_nxt = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = DATA;
      end
      DATA: begin
        wvalid    = pix_valid;
        pix_ready = wready;
        wlast     = (beat == 4'hF);
        if (pix_valid && wready && beat == 4'hF) state_nxt = RESP;
      end
      RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = enable ? ADDR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst/frame bookkeeping: beat counter, frame offset, ring index, status.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      buf_idx    <= '0;
      offset     <= '0;
      beat       <= '0;
      frame_num  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ADDR: if (awready) beat <= '0;
        DATA: begin
          if (pix_valid && wready) begin
            beat <= beat + 4'd1;
            if (beat == 4'hF) offset <= offset + 32'd128;
          end
        end
        RESP: begin
          if (bvalid) begin
            if (bresp != 2'b00) err <= 1'b1;
            if (frame_end) begin
              frame_num  <= buf_idx;
              frame_done <= 1'b1;
              buf_idx    <= (buf_idx == 8'(NUM_FRAMES - 1)) ? '0 : buf_idx + 8'd1;
              offset     <= '0;
            end else if (!enable) begin
              // Abandoned partial frame: restart this same buffer from its start.
              offset <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
